// File: rtl/branch_predictor_pkg.sv
// Shared defaults, types and helpers for the branch predictor slice.
// Parameter defaults give a 64-entry bimodal predictor with 2-bit counters.
package branch_predictor_pkg;

    localparam int PC_W           = 32;
    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_CTR_BITS   = 2;
    localparam int DEF_TAG_BITS   = 8;
    localparam int DEF_GHR_BITS   = 0;
    localparam int DEF_CNT_BITS   = 32;

    typedef enum logic [1:0] {
        CTR_HOLD = 2'd0,
        CTR_INC  = 2'd1,
        CTR_DEC  = 2'd2
    } ctr_op_e;

    // Bimodal builds still carry a 1-bit history field down the pipe.
    function automatic int hist_width(input int ghr_bits);
        return (ghr_bits > 0) ? ghr_bits : 1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and Execute training bundle between the core and the predictor.
// GHR_W must equal max(GHR_BITS,1) of the predictor it is attached to.
interface branch_predictor_if #(
    parameter int GHR_W    = 1,
    parameter int CNT_BITS = 32
);

    logic [31:0]         PCF;
    logic                StallF;
    logic                PredTakenF;
    logic [31:0]         PredTargetF;
    logic                PredHitF;
    logic [GHR_W-1:0]    PredGHRF;

    logic                UpdateEn;
    logic [31:0]         UpdatePC;
    logic [GHR_W-1:0]    UpdateGHR;
    logic                UpdateTaken;
    logic [31:0]         UpdateTarget;
    logic                UpdateMispred;

    logic [CNT_BITS-1:0] BranchCnt;
    logic [CNT_BITS-1:0] MispredCnt;

    modport master (
        output PCF, StallF,
        output UpdateEn, UpdatePC, UpdateGHR, UpdateTaken, UpdateTarget, UpdateMispred,
        input  PredTakenF, PredTargetF, PredHitF, PredGHRF,
        input  BranchCnt, MispredCnt
    );

    modport slave (
        input  PCF, StallF,
        input  UpdateEn, UpdatePC, UpdateGHR, UpdateTaken, UpdateTarget, UpdateMispred,
        output PredTakenF, PredTargetF, PredHitF, PredGHRF,
        output BranchCnt, MispredCnt
    );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-value logic for one up/down saturating counter; holds no state itself.
module branch_predictor_sat_counter
    import branch_predictor_pkg::*;
#(
    parameter int CTR_BITS = DEF_CTR_BITS
) (
    input  logic [CTR_BITS-1:0] cur,
    input  ctr_op_e             op,
    output logic [CTR_BITS-1:0] next
);

    always_comb begin
        next = cur;
        case (op)
            CTR_INC: begin
                if (cur != {CTR_BITS{1'b1}}) begin
                    next = cur + CTR_BITS'(1);
                end
            end
            CTR_DEC: begin
                if (cur != {CTR_BITS{1'b0}}) begin
                    next = cur - CTR_BITS'(1);
                end
            end
            default: next = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direction (counter table) + target (tagged buffer) predictor for Fetch,
// trained by resolved branches from Execute; bimodal or gshare via GHR_BITS.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int CTR_BITS   = DEF_CTR_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS,
    parameter int GHR_BITS   = DEF_GHR_BITS,
    parameter int CNT_BITS   = DEF_CNT_BITS
) (
    input logic               clk,
    input logic               reset,
    branch_predictor_if.slave bp
);

    localparam int  GHR_W   = hist_width(GHR_BITS);
    localparam int  ENTRIES = 1 << INDEX_BITS;
    localparam int  TAG_LO  = INDEX_BITS + 2;
    localparam int  TAG_HI  = INDEX_BITS + TAG_BITS + 1;
    localparam bit  GSHARE  = (GHR_BITS > 0);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];
    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]       target_q [ENTRIES];
    logic [GHR_W-1:0]      ghr_q;
    logic [CNT_BITS-1:0]   branch_cnt_q;
    logic [CNT_BITS-1:0]   mispred_cnt_q;

    logic [INDEX_BITS-1:0] fetch_hist;
    logic [INDEX_BITS-1:0] upd_hist;
    logic [INDEX_BITS-1:0] fetch_bidx;
    logic [INDEX_BITS-1:0] fetch_cidx;
    logic [INDEX_BITS-1:0] upd_bidx;
    logic [INDEX_BITS-1:0] upd_cidx;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  lookup_hit;
    logic                  lookup_taken;
    logic                  upd_mispred;
    logic [CTR_BITS-1:0]   ctr_cur;
    logic [CTR_BITS-1:0]   ctr_next;
    ctr_op_e               ctr_op;
    logic                  unused_pc;

    // History is zero-extended into the index; bimodal builds ignore it entirely.
    if (GSHARE) begin : g_gshare
        assign fetch_hist = INDEX_BITS'(ghr_q);
        assign upd_hist   = INDEX_BITS'(bp.UpdateGHR);
    end else begin : g_bimodal
        logic unused_hist;
        assign unused_hist = ^{ghr_q, bp.UpdateGHR};
        assign fetch_hist  = '0;
        assign upd_hist    = '0;
    end

    assign unused_pc = ^{bp.PCF[PC_W-1:TAG_HI+1], bp.PCF[1:0],
                         bp.UpdatePC[PC_W-1:TAG_HI+1], bp.UpdatePC[1:0]};

    assign fetch_bidx = bp.PCF[INDEX_BITS+1:2];
    assign fetch_cidx = fetch_bidx ^ fetch_hist;
    assign fetch_tag  = bp.PCF[TAG_HI:TAG_LO];
    assign upd_bidx   = bp.UpdatePC[INDEX_BITS+1:2];
    assign upd_cidx   = upd_bidx ^ upd_hist;
    assign upd_tag    = bp.UpdatePC[TAG_HI:TAG_LO];

    assign lookup_hit   = valid_q[fetch_bidx] && (tag_q[fetch_bidx] == fetch_tag);
    assign lookup_taken = lookup_hit && ctr_q[fetch_cidx][CTR_BITS-1];
    assign upd_mispred  = bp.UpdateEn && bp.UpdateMispred;

    assign bp.PredHitF    = lookup_hit;
    assign bp.PredTakenF  = lookup_taken;
    assign bp.PredTargetF = lookup_hit ? target_q[fetch_bidx] : '0;
    assign bp.PredGHRF    = ghr_q;
    assign bp.BranchCnt   = branch_cnt_q;
    assign bp.MispredCnt  = mispred_cnt_q;

    always_comb begin
        ctr_op = CTR_HOLD;
        if (bp.UpdateEn) begin
            if (bp.UpdateTaken) begin
                ctr_op = CTR_INC;
            end else begin
                ctr_op = CTR_DEC;
            end
        end
    end

    assign ctr_cur = ctr_q[upd_cidx];

    branch_predictor_sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_counter (
        .cur  (ctr_cur),
        .op   (ctr_op),
        .next (ctr_next)
    );

    // Lookups read the arrays combinationally, so same-cycle training shows up next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (bp.UpdateEn) begin
            ctr_q[upd_cidx] <= ctr_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (bp.UpdateEn && bp.UpdateTaken) begin
            valid_q[upd_bidx] <= 1'b1;
        end
    end

    // Tag and target are only observed behind a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (bp.UpdateEn && bp.UpdateTaken) begin
            tag_q[upd_bidx]    <= upd_tag;
            target_q[upd_bidx] <= bp.UpdateTarget;
        end
    end

    // A resolved misprediction repairs history and overrides the speculative shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else if (!GSHARE) begin
            ghr_q <= '0;
        end else if (upd_mispred) begin
            ghr_q <= GHR_W'({bp.UpdateGHR, bp.UpdateTaken});
        end else if (!bp.StallF && lookup_hit) begin
            ghr_q <= GHR_W'({ghr_q, lookup_taken});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (bp.UpdateEn && !(&branch_cnt_q)) begin
                branch_cnt_q <= branch_cnt_q + CNT_BITS'(1);
            end
            if (upd_mispred && !(&mispred_cnt_q)) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal instance (4-bit perf counters) and a
// gshare instance (4-bit history), both checked against a reference model.
module tb_branch_predictor;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_bad    = 0;

    branch_predictor_if #(.GHR_W(1), .CNT_BITS(4)) bif0 ();
    branch_predictor_if #(.GHR_W(4), .CNT_BITS(8)) bif1 ();

    branch_predictor #(
        .INDEX_BITS (6), .CTR_BITS (2), .TAG_BITS (8), .GHR_BITS (0), .CNT_BITS (4)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bp    (bif0)
    );

    branch_predictor #(
        .INDEX_BITS (6), .CTR_BITS (2), .TAG_BITS (8), .GHR_BITS (4), .CNT_BITS (8)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bp    (bif1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [3:0]  ghr;
        int          bcnt;
        int          mcnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference state, one row per instance.
    int          m_ctr [2][64];
    bit          m_vld [2][64];
    logic [7:0]  m_tag [2][64];
    logic [31:0] m_tgt [2][64];
    logic [3:0]  m_ghr [2];
    int          m_bcnt[2];
    int          m_mcnt[2];
    int          m_max [2];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) begin
                m_ctr[d][i] = 1;
                m_vld[d][i] = 1'b0;
                m_tag[d][i] = 8'h00;
                m_tgt[d][i] = 32'h0;
            end
            m_ghr[d]  = 4'h0;
            m_bcnt[d] = 0;
            m_mcnt[d] = 0;
        end
        m_max[0] = 15;
        m_max[1] = 255;
    endtask

    function automatic logic [5:0] hist_of(input int d, input logic [3:0] h);
        return (d == 1) ? {2'b00, h} : 6'd0;
    endfunction

    task automatic compare_expected();
        exp_t        e;
        logic        o_hit;
        logic        o_tk;
        logic [31:0] o_tgt;
        logic [3:0]  o_ghr;
        logic [31:0] o_b;
        logic [31:0] o_m;
        if (sb_q.size() == 0) begin
            check_output("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        if (e.d == 0) begin
            o_hit = bif0.PredHitF;   o_tk  = bif0.PredTakenF; o_tgt = bif0.PredTargetF;
            o_ghr = 4'(bif0.PredGHRF);
            o_b   = 32'(bif0.BranchCnt); o_m = 32'(bif0.MispredCnt);
        end else begin
            o_hit = bif1.PredHitF;   o_tk  = bif1.PredTakenF; o_tgt = bif1.PredTargetF;
            o_ghr = bif1.PredGHRF;
            o_b   = 32'(bif1.BranchCnt); o_m = 32'(bif1.MispredCnt);
        end
        check_output($sformatf("d%0d_hit", e.d),   32'(o_hit), 32'(e.hit));
        check_output($sformatf("d%0d_taken", e.d), 32'(o_tk),  32'(e.taken));
        if (e.hit) begin
            check_output($sformatf("d%0d_target", e.d), o_tgt, e.tgt);
        end
        check_output($sformatf("d%0d_ghr", e.d),  32'(o_ghr), 32'(e.ghr));
        check_output($sformatf("d%0d_bcnt", e.d), o_b, 32'(e.bcnt));
        check_output($sformatf("d%0d_mcnt", e.d), o_m, 32'(e.mcnt));
    endtask

    task automatic drive_idle();
        bif0.PCF = 32'h0; bif0.StallF = 1'b1; bif0.UpdateEn = 1'b0; bif0.UpdatePC = 32'h0;
        bif0.UpdateGHR = 1'b0; bif0.UpdateTaken = 1'b0; bif0.UpdateTarget = 32'h0;
        bif0.UpdateMispred = 1'b0;
        bif1.PCF = 32'h0; bif1.StallF = 1'b1; bif1.UpdateEn = 1'b0; bif1.UpdatePC = 32'h0;
        bif1.UpdateGHR = 4'h0; bif1.UpdateTaken = 1'b0; bif1.UpdateTarget = 32'h0;
        bif1.UpdateMispred = 1'b0;
    endtask

    // One cycle: drive, predict from the model, compare mid-cycle, then advance the model.
    task automatic apply_stimulus(input int d, input logic [31:0] pc, input bit stall,
                                  input bit uen, input logic [31:0] upc, input logic [3:0] ughr,
                                  input bit utk, input logic [31:0] utgt, input bit umis);
        exp_t       e;
        logic [5:0] bi;
        logic [5:0] ci;
        logic [5:0] ui;
        drive_idle();
        if (d == 0) begin
            bif0.PCF = pc; bif0.StallF = stall; bif0.UpdateEn = uen; bif0.UpdatePC = upc;
            bif0.UpdateTaken = utk; bif0.UpdateTarget = utgt; bif0.UpdateMispred = umis;
        end else begin
            bif1.PCF = pc; bif1.StallF = stall; bif1.UpdateEn = uen; bif1.UpdatePC = upc;
            bif1.UpdateGHR = ughr; bif1.UpdateTaken = utk; bif1.UpdateTarget = utgt;
            bif1.UpdateMispred = umis;
        end
        bi      = pc[7:2];
        ci      = bi ^ hist_of(d, m_ghr[d]);
        e.d     = d;
        e.hit   = m_vld[d][bi] && (m_tag[d][bi] == pc[15:8]);
        e.taken = e.hit && (m_ctr[d][ci] >= 2);
        e.tgt   = e.hit ? m_tgt[d][bi] : 32'h0;
        e.ghr   = m_ghr[d];
        e.bcnt  = m_bcnt[d];
        e.mcnt  = m_mcnt[d];
        sb_q.push_back(e);
        @(negedge clk);
        compare_expected();
        if (uen) begin
            ui = upc[7:2] ^ hist_of(d, ughr);
            if (utk && m_ctr[d][ui] < 3) m_ctr[d][ui]++;
            else if (!utk && m_ctr[d][ui] > 0) m_ctr[d][ui]--;
            if (utk) begin
                m_vld[d][upc[7:2]] = 1'b1;
                m_tag[d][upc[7:2]] = upc[15:8];
                m_tgt[d][upc[7:2]] = utgt;
            end
            if (m_bcnt[d] < m_max[d]) m_bcnt[d]++;
            if (umis && m_mcnt[d] < m_max[d]) m_mcnt[d]++;
        end
        if (d == 1) begin
            if (uen && umis) m_ghr[1] = {ughr[2:0], utk};
            else if (!stall && e.hit) m_ghr[1] = {m_ghr[1][2:0], e.taken};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input int d, input logic [31:0] pc, input bit stall);
        apply_stimulus(d, pc, stall, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic train(input int d, input logic [31:0] upc, input logic [3:0] ughr,
                         input bit utk, input logic [31:0] utgt, input bit umis);
        apply_stimulus(d, 32'h0, 1'b1, 1'b1, upc, ughr, utk, utgt, umis);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        drive_idle();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        bif0.PCF = 32'h100;
        bif1.PCF = 32'h100;
        #10;
        $display("[TB] reset state");
        check_output("rst_hit0",   32'(bif0.PredHitF),   32'd0);
        check_output("rst_taken0", 32'(bif0.PredTakenF), 32'd0);
        check_output("rst_tgt0",   bif0.PredTargetF,     32'd0);
        check_output("rst_ghr1",   32'(bif1.PredGHRF),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        lookup(0, 32'h100, 1'b0);
        lookup(1, 32'h100, 1'b0);

        $display("[TB] bimodal training");
        apply_stimulus(0, 32'h100, 1'b0, 1'b1, 32'h100, 4'h0, 1'b1, 32'h200, 1'b0);
        apply_stimulus(0, 32'h100, 1'b0, 1'b1, 32'h100, 4'h0, 1'b1, 32'h200, 1'b0);
        lookup(0, 32'h100, 1'b0);
        check_output("bim_hit",    32'(bif0.PredHitF),   32'd1);
        check_output("bim_taken",  32'(bif0.PredTakenF), 32'd1);
        check_output("bim_target", bif0.PredTargetF,     32'h200);

        $display("[TB] saturation and decay");
        for (int i = 0; i < 5; i++) train(0, 32'h140, 4'h0, 1'b1, 32'h240, 1'b0);
        train(0, 32'h140, 4'h0, 1'b0, 32'h0, 1'b0);
        bif0.PCF = 32'h140;
        #1;
        check_output("decay1_taken", 32'(bif0.PredTakenF), 32'd1);
        train(0, 32'h140, 4'h0, 1'b0, 32'h0, 1'b0);
        bif0.PCF = 32'h140;
        #1;
        check_output("decay2_taken", 32'(bif0.PredTakenF), 32'd0);
        check_output("decay2_hit",   32'(bif0.PredHitF),   32'd1);

        $display("[TB] same-cycle update and lookup");
        apply_stimulus(0, 32'h180, 1'b0, 1'b1, 32'h180, 4'h0, 1'b1, 32'h300, 1'b0);
        check_output("rbw_hit_next", 32'(bif0.PredHitF), 32'd1);
        check_output("rbw_tgt_next", bif0.PredTargetF,   32'h300);
        lookup(0, 32'h4100, 1'b0);
        lookup(0, 32'h103, 1'b0);
        check_output("lowbits_target", bif0.PredTargetF, 32'h200);

        $display("[TB] gshare history");
        train(1, 32'h1000, 4'h0, 1'b1, 32'h1100, 1'b0);
        train(1, 32'h1010, 4'h0, 1'b1, 32'h1110, 1'b0);
        train(1, 32'h1020, 4'h2, 1'b1, 32'h1120, 1'b0);
        train(1, 32'h1020, 4'h2, 1'b1, 32'h1120, 1'b0);
        lookup(1, 32'h1000, 1'b0);
        lookup(1, 32'h1010, 1'b0);
        lookup(1, 32'h1020, 1'b0);
        check_output("ghr_0101", 32'(bif1.PredGHRF), 32'h5);
        lookup(1, 32'h1000, 1'b1);
        lookup(1, 32'h1000, 1'b1);
        check_output("ghr_stall_hold", 32'(bif1.PredGHRF), 32'h5);
        apply_stimulus(1, 32'h1000, 1'b0, 1'b1, 32'h1030, 4'h3, 1'b1, 32'h1234, 1'b1);
        check_output("ghr_repair", 32'(bif1.PredGHRF), 32'h7);
        apply_stimulus(1, 32'h0, 1'b1, 1'b0, 32'h1030, 4'h0, 1'b0, 32'h0, 1'b1);
        check_output("ghr_lone_mispred", 32'(bif1.PredGHRF),   32'h7);
        check_output("mcnt_lone_mispred", 32'(bif1.MispredCnt), 32'd1);

        $display("[TB] perf counter saturation");
        for (int i = 0; i < 17; i++) train(0, 32'h2000, 4'h0, 1'b0, 32'h0, 1'b1);
        check_output("mcnt_sat", 32'(bif0.MispredCnt), 32'hF);
        check_output("bcnt_sat", 32'(bif0.BranchCnt),  32'hF);

        $display("[TB] asynchronous reset mid-run");
        bif0.PCF = 32'h100;
        reset = 1'b0;
        #1;
        check_output("midrst_mcnt", 32'(bif0.MispredCnt), 32'd0);
        check_output("midrst_bcnt", 32'(bif0.BranchCnt),  32'd0);
        check_output("midrst_hit",  32'(bif0.PredHitF),   32'd0);
        check_output("midrst_ghr1", 32'(bif1.PredGHRF),   32'd0);
        model_reset();
        #1;
        reset = 1'b1;
        lookup(0, 32'h100, 1'b0);
        apply_stimulus(0, 32'h100, 1'b0, 1'b1, 32'h100, 4'h0, 1'b1, 32'h500, 1'b1);
        lookup(0, 32'h100, 1'b0);
        lookup(1, 32'h1000, 1'b0);

        if (sb_q.size() != 0) check_output("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
